// File: rtl/comma_aligner_pkg.sv
// Shared RX definitions: K28.5 comma codes, the alignment FSM state type and
// the helper that extracts one 10b symbol from the 20-bit search window.
package comma_aligner_pkg;

  localparam logic [9:0] K28_5_RDN = 10'h0FA;
  localparam logic [9:0] K28_5_RDP = 10'h305;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } rx_state_t;

  // Offset k selects window[19-k -: 10]; bit 19 is the earliest received bit.
  function automatic logic [9:0] symbol_at(input logic [19:0] window,
                                           input logic [3:0]  offset);
    logic [19:0] shifted;
    shifted = window << offset;
    return shifted[19:10];
  endfunction

  function automatic logic is_comma(input logic [9:0] sym);
    return (sym == K28_5_RDN) || (sym == K28_5_RDP);
  endfunction

endpackage

// File: rtl/comma_aligner_search.sv
// Parallel K28.5 search over all ten bit offsets of the 20-bit window.
// When several offsets match, the lowest offset is reported.
module comma_search
  import comma_aligner_pkg::*;
(
  input  logic [19:0] window,
  output logic        found,
  output logic [3:0]  offset
);

  always_comb begin
    found  = 1'b0;
    offset = 4'd0;
    // Walk from the highest offset down so the lowest match is written last.
    for (int k = 9; k >= 0; k--) begin
      if (is_comma(symbol_at(window, 4'(k)))) begin
        found  = 1'b1;
        offset = 4'(k);
      end
    end
  end

endmodule

// File: rtl/comma_aligner.sv
// Symbol aligner for a 10b deserializer: finds K28.5 commas at any bit offset,
// qualifies the offset over several commas, then emits aligned symbols.
module comma_aligner
  import comma_aligner_pkg::*;
#(
  parameter int DATA_WIDTH   = 10,
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  symbol_lock,
  output logic                  comma_det,
  output logic [3:0]            align_offset,
  output rx_state_t             fsm_state
);

  localparam int LCNT_W = $clog2(LOCK_COUNT + 1);
  localparam int MCNT_W = $clog2(UNLOCK_COUNT + 1);
  localparam logic [LCNT_W-1:0] LCNT_MAX = '1;
  localparam logic [MCNT_W-1:0] MCNT_MAX = '1;

  logic [DATA_WIDTH-1:0]   word_q;
  logic [2*DATA_WIDTH-1:0] window;
  logic                    found;
  logic [3:0]              found_offset;
  logic                    hit;

  rx_state_t               state_q, state_d;
  logic [3:0]              offset_d;
  logic [LCNT_W-1:0]       lock_cnt, lock_cnt_d;
  logic [MCNT_W-1:0]       miss_cnt, miss_cnt_d;

  logic [DATA_WIDTH-1:0]   data_out_d;
  logic                    lock_d;
  logic                    comma_det_d;

  assign window    = {word_q, data_in};
  assign hit       = found && (found_offset == align_offset);
  assign fsm_state = state_q;

  comma_search u_search (
    .window (window),
    .found  (found),
    .offset (found_offset)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_UNLOCKED;
      align_offset <= 4'd0;
      lock_cnt     <= '0;
      miss_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      align_offset <= offset_d;
      lock_cnt     <= lock_cnt_d;
      miss_cnt     <= miss_cnt_d;
    end
  end

  // Next-state logic; cycles without any comma hold all counters.
  always_comb begin
    state_d    = state_q;
    offset_d   = align_offset;
    lock_cnt_d = lock_cnt;
    miss_cnt_d = miss_cnt;
    case (state_q)
      ST_UNLOCKED: begin
        if (found) begin
          offset_d   = found_offset;
          lock_cnt_d = LCNT_W'(1);
          state_d    = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (found) begin
          if (hit) begin
            if (lock_cnt != LCNT_MAX) lock_cnt_d = lock_cnt + 1'b1;
            if (int'(lock_cnt) + 1 >= LOCK_COUNT) state_d = ST_LOCKED;
          end else begin
            offset_d   = found_offset;
            lock_cnt_d = LCNT_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (found) begin
          if (hit) begin
            miss_cnt_d = '0;
          end else begin
            if (miss_cnt != MCNT_MAX) miss_cnt_d = miss_cnt + 1'b1;
            if (int'(miss_cnt) + 1 >= UNLOCK_COUNT) begin
              state_d    = ST_UNLOCKED;
              miss_cnt_d = '0;
            end
          end
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // Outputs follow the offset being adopted this edge, so the comma that
  // completes lock is itself the first valid symbol.
  always_comb begin
    data_out_d  = symbol_at(window, offset_d);
    lock_d      = (state_d == ST_LOCKED);
    comma_det_d = (state_q == ST_LOCKED) && hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q      <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      symbol_lock <= 1'b0;
      comma_det   <= 1'b0;
    end else begin
      word_q      <= data_in;
      data_out    <= data_out_d;
      data_valid  <= lock_d;
      symbol_lock <= lock_d;
      comma_det   <= comma_det_d;
    end
  end

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: builds a bit-shifted symbol stream and
// checks lock, data path, unlock, miss clearing, restart and async reset.
module tb_comma_aligner;
  import comma_aligner_pkg::*;

  localparam logic [9:0] C_FA = 10'h0FA;
  localparam logic [9:0] D_BB = 10'h2BB;
  localparam logic [9:0] D_CC = 10'h1CC;
  localparam logic [9:0] IDLE = 10'h000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] data_in;
  logic [9:0] data_out;
  logic       data_valid;
  logic       symbol_lock;
  logic       comma_det;
  logic [3:0] align_offset;
  rx_state_t  fsm_state;

  logic [9:0] prev_sym;
  int         checks   = 0;
  int         failures = 0;

  comma_aligner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .symbol_lock  (symbol_lock),
    .comma_det    (comma_det),
    .align_offset (align_offset),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n    = 1'b0;
    data_in  = '0;
    prev_sym = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive one word of a stream whose symbols sit at offset k. The symbol that
  // completes in the window this cycle is the one sent by the previous call.
  task automatic send(input logic [9:0] s, input int k);
    logic [19:0] pair;
    pair     = {prev_sym, s} >> k;
    data_in  = pair[9:0];
    prev_sym = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_in = 10'h3FF;
    #1;
    checks++; if (data_out !== 10'h000) begin failures++; $display("FAIL reset_data_out got=%h exp=000", data_out); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    checks++; if (symbol_lock !== 1'b0) begin failures++; $display("FAIL reset_symbol_lock got=%b exp=0", symbol_lock); end
    checks++; if (comma_det !== 1'b0) begin failures++; $display("FAIL reset_comma_det got=%b exp=0", comma_det); end
    checks++; if (align_offset !== 4'd0) begin failures++; $display("FAIL reset_align_offset got=%0d exp=0", align_offset); end
    checks++; if (fsm_state !== ST_UNLOCKED) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    do_reset();
  endtask

  task automatic test_lock();
    send(C_FA, 3);
    checks++; if (fsm_state !== ST_UNLOCKED) begin failures++; $display("FAIL lock_no_early_comma got=%0d exp=0", fsm_state); end
    send(C_FA, 3);
    checks++; if (align_offset !== 4'd3) begin failures++; $display("FAIL lock_first_offset got=%0d exp=3", align_offset); end
    checks++; if (fsm_state !== ST_CHECK) begin failures++; $display("FAIL lock_check_state got=%0d exp=1", fsm_state); end
    checks++; if (data_out !== C_FA) begin failures++; $display("FAIL lock_tracks_offset got=%h exp=0fa", data_out); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL lock_valid_in_check got=%b exp=0", data_valid); end
    send(IDLE, 3);
    checks++; if (symbol_lock !== 1'b0) begin failures++; $display("FAIL lock_after_two got=%b exp=0", symbol_lock); end
    send(IDLE, 3);
    checks++; if (symbol_lock !== 1'b0) begin failures++; $display("FAIL lock_idle_holds got=%b exp=0", symbol_lock); end
    // third comma; idle cycle above must not have disturbed lock_cnt
    send(C_FA, 3);
    send(IDLE, 3);
    checks++; if (symbol_lock !== 1'b1) begin failures++; $display("FAIL lock_third got=%b exp=1", symbol_lock); end
    checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL lock_valid got=%b exp=1", data_valid); end
    checks++; if (data_out !== C_FA) begin failures++; $display("FAIL lock_first_symbol got=%h exp=0fa", data_out); end
    checks++; if (align_offset !== 4'd3) begin failures++; $display("FAIL lock_offset got=%0d exp=3", align_offset); end
  endtask

  task automatic test_data();
    logic [9:0] syms [5];
    logic [9:0] exp_out [5];
    logic       exp_det [5];
    syms    = '{C_FA, D_BB, D_CC, C_FA, IDLE};
    exp_out = '{IDLE, C_FA, D_BB, D_CC, C_FA};
    exp_det = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      send(syms[i], 3);
      checks++; if (data_out !== exp_out[i]) begin failures++; $display("FAIL data_out[%0d] got=%h exp=%h", i, data_out, exp_out[i]); end
      checks++; if (comma_det !== exp_det[i]) begin failures++; $display("FAIL data_comma_det[%0d] got=%b exp=%b", i, comma_det, exp_det[i]); end
      checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL data_valid[%0d] got=%b exp=1", i, data_valid); end
    end
  endtask

  task automatic test_unlock_relock();
    send(C_FA, 7);
    for (int i = 0; i < 3; i++) send(C_FA, 7);
    checks++; if (symbol_lock !== 1'b1) begin failures++; $display("FAIL unlock_after_three got=%b exp=1", symbol_lock); end
    checks++; if (comma_det !== 1'b0) begin failures++; $display("FAIL unlock_no_det got=%b exp=0", comma_det); end
    send(IDLE, 7);
    checks++; if (symbol_lock !== 1'b0) begin failures++; $display("FAIL unlock_after_four got=%b exp=0", symbol_lock); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL unlock_valid got=%b exp=0", data_valid); end
    checks++; if (fsm_state !== ST_UNLOCKED) begin failures++; $display("FAIL unlock_state got=%0d exp=0", fsm_state); end
    send(C_FA, 7);
    send(C_FA, 7);
    checks++; if (align_offset !== 4'd7) begin failures++; $display("FAIL relock_offset_check got=%0d exp=7", align_offset); end
    send(C_FA, 7);
    checks++; if (symbol_lock !== 1'b0) begin failures++; $display("FAIL relock_early got=%b exp=0", symbol_lock); end
    send(IDLE, 7);
    checks++; if (symbol_lock !== 1'b1) begin failures++; $display("FAIL relock got=%b exp=1", symbol_lock); end
    checks++; if (align_offset !== 4'd7) begin failures++; $display("FAIL relock_offset got=%0d exp=7", align_offset); end
    checks++; if (data_out !== C_FA) begin failures++; $display("FAIL relock_symbol got=%h exp=0fa", data_out); end
  endtask

  task automatic test_miss_clear();
    send(C_FA, 2);
    send(C_FA, 2);
    send(C_FA, 2);
    send(IDLE, 2);
    checks++; if (symbol_lock !== 1'b1) begin failures++; $display("FAIL miss_three_wrong got=%b exp=1", symbol_lock); end
    send(C_FA, 7);
    send(IDLE, 7);
    checks++; if (comma_det !== 1'b1) begin failures++; $display("FAIL miss_correct_det got=%b exp=1", comma_det); end
    checks++; if (data_out !== C_FA) begin failures++; $display("FAIL miss_correct_symbol got=%h exp=0fa", data_out); end
    send(C_FA, 2);
    send(C_FA, 2);
    send(C_FA, 2);
    send(IDLE, 2);
    checks++; if (symbol_lock !== 1'b1) begin failures++; $display("FAIL miss_cleared_hold got=%b exp=1", symbol_lock); end
    checks++; if (align_offset !== 4'd7) begin failures++; $display("FAIL miss_offset_hold got=%0d exp=7", align_offset); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", data_valid); end
    checks++; if (symbol_lock !== 1'b0) begin failures++; $display("FAIL areset_lock got=%b exp=0", symbol_lock); end
    checks++; if (data_out !== 10'h000) begin failures++; $display("FAIL areset_data_out got=%h exp=000", data_out); end
    checks++; if (align_offset !== 4'd0) begin failures++; $display("FAIL areset_offset got=%0d exp=0", align_offset); end
    #1;
    rst_n    = 1'b1;
    prev_sym = '0;
    send(C_FA, 3);
    send(C_FA, 3);
    send(C_FA, 3);
    checks++; if (symbol_lock !== 1'b0) begin failures++; $display("FAIL areset_relock_early got=%b exp=0", symbol_lock); end
    send(IDLE, 3);
    checks++; if (symbol_lock !== 1'b1) begin failures++; $display("FAIL areset_relock got=%b exp=1", symbol_lock); end
    checks++; if (align_offset !== 4'd3) begin failures++; $display("FAIL areset_relock_offset got=%0d exp=3", align_offset); end
  endtask

  task automatic test_check_restart();
    do_reset();
    send(C_FA, 3);
    send(C_FA, 3);
    send(IDLE, 3);
    checks++; if (fsm_state !== ST_CHECK) begin failures++; $display("FAIL restart_in_check got=%0d exp=1", fsm_state); end
    send(C_FA, 5);
    send(IDLE, 5);
    checks++; if (align_offset !== 4'd5) begin failures++; $display("FAIL restart_offset got=%0d exp=5", align_offset); end
    checks++; if (symbol_lock !== 1'b0) begin failures++; $display("FAIL restart_no_lock got=%b exp=0", symbol_lock); end
    send(C_FA, 5);
    send(C_FA, 5);
    checks++; if (symbol_lock !== 1'b0) begin failures++; $display("FAIL restart_second got=%b exp=0", symbol_lock); end
    send(IDLE, 5);
    checks++; if (symbol_lock !== 1'b1) begin failures++; $display("FAIL restart_lock got=%b exp=1", symbol_lock); end
    checks++; if (align_offset !== 4'd5) begin failures++; $display("FAIL restart_lock_offset got=%0d exp=5", align_offset); end
  endtask

  initial begin
    prev_sym = '0;
    test_reset();
    test_lock();
    test_data();
    test_unlock_relock();
    test_miss_clear();
    test_async_reset();
    test_check_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
